// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------------------------
// vga_sync_decoder
//
// Receive-side monitor for a VGA timing stream. Samples HS/VS/RGB on each pixel strobe, checks
// the sync timing against a fixed template (640x480@60 by default), recovers the coordinate of
// every sampled pixel and reports lock state plus saturating HS/VS timing error counts.
//
// Ports
//   CLK_50      in   1   sole clock
//   RST         in   1   synchronous, active-high reset
//   PIX_EN      in   1   pixel strobe; all inputs are sampled only when high
//   VGA_HS      in   1   horizontal sync under test
//   VGA_VS      in   1   vertical sync under test
//   VGA_BUS_R   in   4   red
//   VGA_BUS_G   in   4   green
//   VGA_BUS_B   in   4   blue
//   X_PIX       out 10   recovered column of the captured pixel
//   Y_PIX       out 10   recovered row of the captured pixel
//   PIX_COLOR   out 12   {B,G,R} of the captured pixel
//   PIX_VALID   out  1   captured pixel is visible and the decoder is locked
//   FRAME_DONE  out  1   one-cycle pulse with the last visible pixel of a frame
//   LOCKED      out  1   timing lock achieved
//   HS_ERR_CNT  out  8   saturating HS timing error count
//   VS_ERR_CNT  out  8   saturating VS timing error count
//
// The coordinate registers hold the position of the previously sampled pixel; the position of
// the pixel being sampled is always the derived "next" value, which is what gets captured.
// ---------------------------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int unsigned H_VISIBLE       = 640,
  parameter int unsigned H_FP            = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BP            = 48,
  parameter int unsigned V_VISIBLE       = 480,
  parameter int unsigned V_FP            = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BP            = 33,
  parameter int unsigned LOCK_FRAMES     = 2,
  parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
  input  logic       CLK_50,
  input  logic       RST,
  input  logic       PIX_EN,
  input  logic       VGA_HS,
  input  logic       VGA_VS,
  input  logic [3:0] VGA_BUS_R,
  input  logic [3:0] VGA_BUS_G,
  input  logic [3:0] VGA_BUS_B,
  output logic [9:0] X_PIX,
  output logic [9:0] Y_PIX,
  output logic [11:0] PIX_COLOR,
  output logic       PIX_VALID,
  output logic       FRAME_DONE,
  output logic       LOCKED,
  output logic [7:0] HS_ERR_CNT,
  output logic [7:0] VS_ERR_CNT
);

  // ------------------------------------------------------------------------------------------
  // Template constants
  // ------------------------------------------------------------------------------------------
  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast      = 10'(HTotal - 1);
  localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] HVisible   = 10'(H_VISIBLE);
  localparam logic [9:0] HVisLast   = 10'(H_VISIBLE - 1);

  localparam logic [9:0] VLast      = 10'(VTotal - 1);
  localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] VVisible   = 10'(V_VISIBLE);
  localparam logic [9:0] VVisLast   = 10'(V_VISIBLE - 1);

  localparam int unsigned GoodW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [GoodW-1:0] LockCount = GoodW'(LOCK_FRAMES);

  localparam bit SyncLow = (SYNC_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    StSearch,
    StAlign,
    StLocked
  } state_e;

  // ------------------------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             locked_q, locked_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             hs_prev_q, hs_prev_d;
  logic             vs_prev_q, vs_prev_d;
  logic             hs_seen_q, hs_seen_d;     // HS leading edge seen since the last line wrap
  logic             frame_err_q, frame_err_d; // any error since the last VS leading edge
  logic [GoodW-1:0] good_q, good_d;
  logic [7:0]       hs_cnt_q, hs_cnt_d;
  logic [7:0]       vs_cnt_q, vs_cnt_d;

  logic [9:0]       x_pix_q, x_pix_d;
  logic [9:0]       y_pix_q, y_pix_d;
  logic [11:0]      pix_color_q, pix_color_d;
  logic             pix_valid_q, pix_valid_d;
  logic             frame_done_q, frame_done_d;

  // ------------------------------------------------------------------------------------------
  // Per-sample decode
  // ------------------------------------------------------------------------------------------
  logic             hs_act, vs_act;
  logic             hs_lead, hs_trail, vs_lead, vs_trail;
  logic             h_at_last, line_end;
  logic [9:0]       h_free, h_next;
  logic [9:0]       v_free, v_next;
  logic             checking;
  logic             hs_err, vs_err, any_err;
  logic             visible;
  logic [GoodW-1:0] good_inc;

  always_comb begin
    hs_act   = SyncLow ? ~VGA_HS : VGA_HS;
    vs_act   = SyncLow ? ~VGA_VS : VGA_VS;
    hs_lead  = hs_act & ~hs_prev_q;
    hs_trail = ~hs_act & hs_prev_q;
    vs_lead  = vs_act & ~vs_prev_q;
    vs_trail = ~vs_act & vs_prev_q;

    // Free-running horizontal position; an HS leading edge re-anchors it to the sync start.
    h_at_last = (h_q == HLast);
    h_free    = h_at_last ? 10'd0 : h_q + 10'd1;
    h_next    = hs_lead ? HSyncStart : h_free;
    line_end  = h_at_last & ~hs_lead;

    // Line advance only on a real wrap; a VS leading edge overrides it.
    if (line_end) begin
      v_free = (v_q == VLast) ? 10'd0 : v_q + 10'd1;
    end else begin
      v_free = v_q;
    end
    v_next = vs_lead ? VSyncStart : v_free;

    checking = (state_q != StSearch);
    hs_err   = checking & ((hs_lead & (h_free != HSyncStart)) |
                           (hs_trail & (h_next != HSyncEnd)) |
                           (line_end & ~hs_seen_q));
    vs_err   = checking & ((vs_lead & (v_free != VSyncStart)) |
                           (vs_trail & (v_next != VSyncEnd)));
    any_err  = hs_err | vs_err;

    visible  = (h_next < HVisible) & (v_next < VVisible);
    good_inc = good_q + 1'b1;
  end

  // ------------------------------------------------------------------------------------------
  // Next state: nothing moves without a pixel strobe, except the output pulses which drop.
  // ------------------------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    v_d          = v_q;
    hs_prev_d    = hs_prev_q;
    vs_prev_d    = vs_prev_q;
    hs_seen_d    = hs_seen_q;
    frame_err_d  = frame_err_q;
    good_d       = good_q;
    hs_cnt_d     = hs_cnt_q;
    vs_cnt_d     = vs_cnt_q;
    x_pix_d      = x_pix_q;
    y_pix_d      = y_pix_q;
    pix_color_d  = pix_color_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    if (PIX_EN) begin
      h_d       = h_next;
      v_d       = v_next;
      hs_prev_d = hs_act;
      vs_prev_d = vs_act;

      if (line_end) begin
        hs_seen_d = 1'b0;
      end else if (hs_lead) begin
        hs_seen_d = 1'b1;
      end

      if (hs_err && (hs_cnt_q != 8'hFF)) begin
        hs_cnt_d = hs_cnt_q + 8'd1;
      end
      if (vs_err && (vs_cnt_q != 8'hFF)) begin
        vs_cnt_d = vs_cnt_q + 8'd1;
      end

      x_pix_d      = h_next;
      y_pix_d      = v_next;
      pix_color_d  = {VGA_BUS_B, VGA_BUS_G, VGA_BUS_R};
      pix_valid_d  = (state_q == StLocked) & visible;
      frame_done_d = pix_valid_d & (h_next == HVisLast) & (v_next == VVisLast);

      // A VS leading edge opens a new frame for the clean-frame bookkeeping.
      if (vs_lead) begin
        frame_err_d = 1'b0;
      end else if (any_err) begin
        frame_err_d = 1'b1;
      end

      unique case (state_q)
        StSearch: begin
          if (vs_lead) begin
            state_d = StAlign;
            good_d  = '0;
          end
        end
        StAlign: begin
          if (vs_lead) begin
            // Errors on the edge sample itself still belong to the frame being closed.
            if (!frame_err_q && !any_err) begin
              good_d = good_inc;
              if (good_inc == LockCount) begin
                state_d = StLocked;
              end
            end else begin
              good_d = '0;
            end
          end
        end
        StLocked: begin
          if (any_err) begin
            state_d = StAlign;
            good_d  = '0;
          end
        end
        default: begin
          state_d = StSearch;
          good_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == StLocked);
  end

  // ------------------------------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------------------------------
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      state_q      <= StSearch;
      locked_q     <= 1'b0;
      h_q          <= '0;
      v_q          <= '0;
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      hs_seen_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      good_q       <= '0;
      hs_cnt_q     <= '0;
      vs_cnt_q     <= '0;
      x_pix_q      <= '0;
      y_pix_q      <= '0;
      pix_color_q  <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      locked_q     <= locked_d;
      h_q          <= h_d;
      v_q          <= v_d;
      hs_prev_q    <= hs_prev_d;
      vs_prev_q    <= vs_prev_d;
      hs_seen_q    <= hs_seen_d;
      frame_err_q  <= frame_err_d;
      good_q       <= good_d;
      hs_cnt_q     <= hs_cnt_d;
      vs_cnt_q     <= vs_cnt_d;
      x_pix_q      <= x_pix_d;
      y_pix_q      <= y_pix_d;
      pix_color_q  <= pix_color_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign X_PIX      = x_pix_q;
  assign Y_PIX      = y_pix_q;
  assign PIX_COLOR  = pix_color_q;
  assign PIX_VALID  = pix_valid_q;
  assign FRAME_DONE = frame_done_q;
  assign LOCKED     = locked_q;
  assign HS_ERR_CNT = hs_cnt_q;
  assign VS_ERR_CNT = vs_cnt_q;

endmodule
